// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash responder model.
// Opcodes, JEDEC ID bytes, FSM states and the memory write bundle.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_TX,
    ST_PROG,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_DREAD = 8'h3B;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  localparam logic [7:0] ID_MFR  = 8'hEF;
  localparam logic [7:0] ID_TYPE = 8'h40;
  localparam logic [7:0] ID_CAP  = 8'h18;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_wr_t;

  function automatic logic [7:0] id_byte(
    input logic [1:0] idx
  );
    case (idx)
      2'd0:    id_byte = ID_MFR;
      2'd1:    id_byte = ID_TYPE;
      2'd2:    id_byte = ID_CAP;
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_resp_mem.sv
// 256x8 array for the flash responder.
// One synchronous write port, one combinational read port, no reset.
module spi_flash_resp_mem
  import spi_flash_pkg::*;
(
  input  logic       i_clk_spi_flash,
  input  mem_wr_t    wr,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge i_clk_spi_flash) begin
    if (wr.we) mem[wr.addr] <= wr.data;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_flash_responder.sv
// Behavioural SPI NOR flash responder: read/dual/quad read,
// page program, ID, status and write-enable latch.
module spi_flash_responder
  import spi_flash_pkg::*;
(
  input  logic       i_clk_spi_flash,
  input  logic       i_rstn_spi_flash,
  input  logic       i_spi_flash_csn,
  input  logic       i_spi_flash_clk_en,
  input  logic [3:0] i_spi_flash_so,
  output logic [3:0] o_spi_flash_si,
  output logic [3:0] o_spi_flash_si_oen,
  input  logic       i_ld_valid,
  input  logic [7:0] i_ld_addr,
  input  logic [7:0] i_ld_data,
  output logic       o_busy
);

  state_e     state;
  logic [7:0] op;
  logic [7:0] sh;
  logic [4:0] cnt;
  logic [7:0] addr;
  logic [2:0] lanes;
  logic [1:0] id_idx;
  logic       wel;
  logic       wrote;

  logic       so0;
  logic [7:0] byte_in;
  logic [7:0] raddr;
  logic [7:0] rdata;
  logic       tx_done;
  logic       prog_we;
  mem_wr_t    wr;
  logic       unused_so;

  assign so0       = i_spi_flash_so[0];
  assign unused_so = ^i_spi_flash_so[3:1];
  assign byte_in   = {sh[6:0], so0};
  assign tx_done   = (cnt + {2'b0, lanes}) == 5'd8;
  assign o_busy    = state != ST_IDLE;

  assign prog_we = i_rstn_spi_flash && !i_spi_flash_csn
                && i_spi_flash_clk_en && state == ST_PROG
                && cnt == 5'd7;

  // Read address is chosen so the next TX byte is ready at the load edge
  always_comb begin
    case (state)
      ST_ADDR: raddr = {addr[6:0], so0};
      ST_TX:   raddr = addr + 8'd1;
      default: raddr = addr;
    endcase
  end

  always_comb begin
    wr = '0;
    if (prog_we) begin
      wr = '{we: 1'b1, addr: addr, data: byte_in};
    end else if (i_ld_valid) begin
      wr = '{we: 1'b1, addr: i_ld_addr, data: i_ld_data};
    end
  end

  spi_flash_resp_mem u_mem (
    .i_clk_spi_flash (i_clk_spi_flash),
    .wr              (wr),
    .raddr           (raddr),
    .rdata           (rdata)
  );

  always_ff @(posedge i_clk_spi_flash) begin
    if (!i_rstn_spi_flash) begin
      state  <= ST_IDLE;
      op     <= '0;
      sh     <= '0;
      cnt    <= '0;
      addr   <= '0;
      lanes  <= 3'b001;
      id_idx <= '0;
      wel    <= 1'b0;
      wrote  <= 1'b0;
    end else if (i_spi_flash_csn) begin
      if (op == OP_PP && wrote) wel <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      wrote <= 1'b0;
    end else if (i_spi_flash_clk_en) begin
      unique case (state)
        ST_IDLE: begin
          state <= ST_CMD;
          sh    <= {7'b0, so0};
          cnt   <= 5'd1;
        end
        ST_CMD: begin
          sh  <= byte_in;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd7) begin
            op    <= byte_in;
            cnt   <= '0;
            lanes <= 3'b001;
            case (byte_in)
              OP_READ:  state <= ST_ADDR;
              OP_DREAD: begin
                state <= ST_ADDR;
                lanes <= 3'b010;
              end
              OP_QREAD: begin
                state <= ST_ADDR;
                lanes <= 3'b100;
              end
              OP_PP: state <= wel ? ST_ADDR : ST_IGNORE;
              OP_RDID: begin
                state  <= ST_TX;
                sh     <= ID_MFR;
                id_idx <= 2'd1;
              end
              OP_RDSR: begin
                state <= ST_TX;
                sh    <= {6'b0, wel, 1'b0};
              end
              OP_WREN: begin
                wel   <= 1'b1;
                state <= ST_IGNORE;
              end
              OP_WRDI: begin
                wel   <= 1'b0;
                state <= ST_IGNORE;
              end
              default: state <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          addr <= {addr[6:0], so0};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt <= '0;
            if (op == OP_READ) begin
              state <= ST_TX;
              sh    <= rdata;
            end else if (op == OP_PP) begin
              state <= ST_PROG;
            end else begin
              state <= ST_DUMMY;
            end
          end
        end
        ST_DUMMY: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt   <= '0;
            state <= ST_TX;
            sh    <= rdata;
          end
        end
        ST_TX: begin
          if (tx_done) begin
            cnt <= '0;
            if (op == OP_RDID) begin
              sh     <= id_byte(id_idx);
              id_idx <= (id_idx == 2'd3) ? id_idx : id_idx + 2'd1;
            end else if (op == OP_RDSR) begin
              sh <= {6'b0, wel, 1'b0};
            end else begin
              sh   <= rdata;
              addr <= addr + 8'd1;
            end
          end else begin
            sh  <= sh << lanes;
            cnt <= cnt + {2'b0, lanes};
          end
        end
        ST_PROG: begin
          sh  <= byte_in;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt   <= '0;
            addr  <= addr + 8'd1;
            wrote <= 1'b1;
          end
        end
        ST_IGNORE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_spi_flash_si     = 4'h0;
    o_spi_flash_si_oen = 4'hF;
    if (state == ST_TX) begin
      unique case (1'b1)
        lanes[2]: begin
          o_spi_flash_si     = sh[7:4];
          o_spi_flash_si_oen = 4'b0000;
        end
        lanes[1]: begin
          o_spi_flash_si     = {2'b0, sh[7:6]};
          o_spi_flash_si_oen = 4'b1100;
        end
        default: begin
          o_spi_flash_si     = {3'b0, sh[7]};
          o_spi_flash_si_oen = 4'b1110;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder.
// Drives on negedge, samples on negedge after the active edge.
module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic       csn;
  logic       en;
  logic [3:0] so;
  logic [3:0] si;
  logic [3:0] oen;
  logic       ld_valid;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       busy;
  logic [7:0] b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_qd [3] = '{8'hA5, 8'h5A, 8'hC3};
  logic [7:0] exp_id [4] = '{8'hEF, 8'h40, 8'h18, 8'h00};

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .i_clk_spi_flash    (clk),
    .i_rstn_spi_flash   (rstn),
    .i_spi_flash_csn    (csn),
    .i_spi_flash_clk_en (en),
    .i_spi_flash_so     (so),
    .o_spi_flash_si     (si),
    .o_spi_flash_si_oen (oen),
    .i_ld_valid         (ld_valid),
    .i_ld_addr          (ld_addr),
    .i_ld_data          (ld_data),
    .o_busy             (busy)
  );

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic slot(input logic bit_v);
    @(negedge clk);
    csn = 1'b0;
    en  = 1'b1;
    so  = {3'b0, bit_v};
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) slot(v[i]);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [7:0] a);
    send_byte(op);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(a);
  endtask

  task automatic end_txn();
    @(negedge clk);
    csn      = 1'b1;
    en       = 1'b0;
    so       = 4'h0;
    ld_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_byte(
    input  int         lanes,
    input  logic [3:0] xoen,
    input  int         stall_at,
    output logic [7:0] v
  );
    logic [3:0] hold;
    v = '0;
    for (int s = 0; s < 8 / lanes; s++) begin
      @(negedge clk);
      check("oen", {4'h0, oen}, {4'h0, xoen});
      check("si_off", {4'h0, si & oen}, 8'h00);
      case (lanes)
        4:       v = {v[3:0], si};
        2:       v = {v[5:0], si[1:0]};
        default: v = {v[6:0], si[0]};
      endcase
      if (s == stall_at) begin
        hold = si;
        en   = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_si", {4'h0, si}, {4'h0, hold});
          check("stall_oen", {4'h0, oen}, {4'h0, xoen});
          check("stall_busy", {7'h0, busy}, 8'h01);
        end
      end
      csn = 1'b0;
      en  = 1'b1;
    end
  endtask

  task automatic read1(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] exp
  );
    logic [7:0] v;
    send_hdr(8'h03, a);
    read_byte(1, 4'b1110, -1, v);
    check(tag, v, exp);
    end_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; csn = 1'b1; en = 1'b0; so = 4'h0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst_si", {4'h0, si}, 8'h00);
    check("rst_oen", {4'h0, oen}, 8'h0F);
    check("rst_busy", {7'h0, busy}, 8'h00);
    rstn = 1'b1;

    preload(8'h10, 8'h11);
    preload(8'h11, 8'h22);
    preload(8'h12, 8'h33);
    preload(8'h13, 8'h44);
    preload(8'hFE, 8'hA5);
    preload(8'hFF, 8'h5A);
    preload(8'h00, 8'hC3);
    preload(8'h20, 8'h77);

    // single-lane read stream
    send_hdr(8'h03, 8'h10);
    for (int i = 0; i < 4; i++) begin
      read_byte(1, 4'b1110, -1, b);
      check("read", b, exp_rd[i]);
    end
    end_txn();
    check("end_oen", {4'h0, oen}, 8'h0F);
    check("end_busy", {7'h0, busy}, 8'h00);

    // quad read across the address wrap
    send_hdr(8'h6B, 8'hFE);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      read_byte(4, 4'b0000, -1, b);
      check("qread", b, exp_qd[i]);
    end
    end_txn();

    // program without WEL is ignored
    send_hdr(8'h02, 8'h20);
    send_byte(8'hAB);
    end_txn();
    read1("pp_nowel", 8'h20, 8'h77);

    send_byte(8'h06);
    end_txn();
    send_byte(8'h05);
    read_byte(1, 4'b1110, -1, b);
    check("sr_wel", b, 8'h02);
    end_txn();

    // program with a colliding backdoor write on the last bit
    send_hdr(8'h02, 8'h20);
    for (int i = 7; i >= 1; i--) slot(b_ab(i));
    slot(1'b1);
    ld_valid = 1'b1;
    ld_addr  = 8'h20;
    ld_data  = 8'h55;
    @(negedge clk);
    ld_valid = 1'b0;
    check("pp_busy", {7'h0, busy}, 8'h01);
    end_txn();
    read1("pp_wel", 8'h20, 8'hAB);

    send_byte(8'h05);
    read_byte(1, 4'b1110, -1, b);
    check("sr_clr", b, 8'h00);
    end_txn();

    send_byte(8'h9F);
    for (int i = 0; i < 4; i++) begin
      read_byte(1, 4'b1110, -1, b);
      check("rdid", b, exp_id[i]);
    end
    end_txn();

    // abort mid-address
    send_byte(8'h03);
    slot(1'b0);
    slot(1'b0);
    slot(1'b0);
    @(negedge clk);
    check("abort_pre", {7'h0, busy}, 8'h01);
    csn = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    check("abort_busy", {7'h0, busy}, 8'h00);
    check("abort_oen", {4'h0, oen}, 8'h0F);
    read1("post_abort", 8'h11, 8'h22);

    // unknown opcode drives nothing
    send_byte(8'hAA);
    read_byte(1, 4'hF, -1, b);
    check("ign_data", b, 8'h00);
    check("ign_busy", {7'h0, busy}, 8'h01);
    end_txn();

    // stalled read resumes intact
    send_hdr(8'h03, 8'h12);
    read_byte(1, 4'b1110, 3, b);
    check("stall_rd", b, 8'h33);
    read_byte(1, 4'b1110, -1, b);
    check("resume_rd", b, 8'h44);
    end_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  function automatic logic b_ab(input int i);
    logic [7:0] v;
    v = 8'hAB;
    return v[i];
  endfunction

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have port i_clk_spi_flash, input, 1: the only clock; all logic samples on its rising edge.
REQ-002 SHALL have port i_rstn_spi_flash, input, 1: synchronous active-low reset.
REQ-003 SHALL have port i_spi_flash_csn, input, 1: chip select from the controller, active low.
REQ-004 SHALL have port i_spi_flash_clk_en, input, 1: SPI bit-clock qualifier; a bit slot is a rising edge with csn=0 and clk_en=1.
REQ-005 SHALL have port i_spi_flash_so, input, 4: controller-driven IO lines [3:0].
REQ-006 SHALL have port o_spi_flash_si, output, 4: responder-driven IO lines [3:0] back to the controller.
REQ-007 SHALL have port o_spi_flash_si_oen, output, 4: per-line output enable, active low; 1 = released.
REQ-008 SHALL have ports i_ld_valid (input, 1), i_ld_addr (input, 8) and i_ld_data (input, 8): backdoor memory preload.
REQ-009 SHALL have port o_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-010 SHALL hold an internal 256x8 memory; only address bits [7:0] are used, bits [23:8] are ignored, and incrementing wraps 0xFF->0x00.
REQ-011 SHALL receive the opcode, address and dummy bytes single-lane on so[0], MSB first, one bit per bit slot.
REQ-012 SHALL implement states IDLE, CMD, ADDR, DUMMY, TX, PROG and IGNORE.
REQ-013 SHALL go from IDLE to CMD when csn=0, and SHALL sample the first opcode bit in that same bit slot.
REQ-014 SHALL decode the opcode on its 8th bit: 0x03 -> ADDR; 0x3B -> ADDR; 0x6B -> ADDR; 0x02 with WEL=1 -> ADDR; 0x02 with WEL=0 -> IGNORE; 0x9F -> TX (ID); 0x05 -> TX (status); 0x06 -> set WEL, then IGNORE; 0x04 -> clear WEL, then IGNORE; any other opcode -> IGNORE.
REQ-015 SHALL leave ADDR after 24 bits: to DUMMY for 0x3B/0x6B, to TX for 0x03, and to PROG for 0x02.
REQ-016 SHALL stay in DUMMY for 8 bit slots, then enter TX.
REQ-017 SHALL set the TX lane width to 1 for 0x03/0x9F/0x05, 2 for 0x3B and 4 for 0x6B.
- Dual: si[1]=byte[7-k], si[0]=byte[6-k].
- Quad: si[3:0]=byte[7-k:4-k].
- k steps by the lane width per bit slot.
REQ-018 SHALL drive TX outputs combinationally from the registered state and shift register, so the first data bit is valid in the first cycle after the last address/dummy bit slot.
REQ-019 SHALL, in TX, drive oen low only on the active lanes; inactive lanes SHALL have oen=1 and si=0.
REQ-020 SHALL, after each complete TX byte, load mem[addr+1] and increment addr, streaming indefinitely while csn=0.
REQ-021 SHALL return 0xEF, 0x40, 0x18 for ID (0x9F), then 0x00 for every following byte.
REQ-022 SHALL return {6'b0, WEL, 1'b0} for status (0x05), repeated every byte.
REQ-023 SHALL, in PROG, assemble bytes from so[0] MSB first, write each complete byte to mem[addr] on its 8th bit slot, then increment addr.
REQ-024 SHALL, in IGNORE, sample nothing and drive nothing.
REQ-025 SHALL treat csn=1 in any state as a synchronous return to IDLE on that edge.
- Partial bytes are discarded; no memory write occurs for them.
- WEL clears if the aborted transaction was 0x02 and at least one byte was written.
REQ-026 SHALL, when clk_en=0 with csn=0, hold the state, counters and outputs unchanged.
REQ-027 SHALL, outside TX, drive oen=4'hF and si=4'h0.
REQ-028 SHALL give a PROG write priority when it occurs in the same cycle as an i_ld_valid write to the same address; the backdoor write is dropped.

Reset
REQ-029 SHALL, while i_rstn_spi_flash=0 at a clock edge, set state=IDLE, WEL=0, counters=0, o_spi_flash_si=4'h0, o_spi_flash_si_oen=4'hF and o_busy=0.
REQ-030 SHALL NOT clear memory contents on reset.
REQ-031 SHALL abandon any transaction in progress when reset occurs mid-transaction.

Structure
REQ-032 SHALL place the opcode constants, the ID bytes and the state enum in shared package spi_flash_pkg.
REQ-033 SHALL implement the memory in sub-module spi_flash_resp_mem: 256x8, one synchronous write port (PROG/backdoor mux), one combinational read port.

Verification
REQ-034 Bench SHALL preload mem[0x10..0x13]=0x11,0x22,0x33,0x44, then send 0x03 00 00 10 and read 4 bytes -> si[0] stream is 0x11,0x22,0x33,0x44 with oen=4'b1110.
REQ-035 Bench SHALL send 0x6B 00 00 FE plus a dummy byte, with mem[0xFE]=0xA5 and mem[0xFF]=0x5A, and read 3 bytes -> 0xA5, 0x5A, then mem[0x00] (wrap), with oen=4'b0000 and 2 slots per byte.
REQ-036 Bench SHALL send 0x02 00 00 20 AB without a prior 0x06 -> mem[0x20] is unchanged; then send 0x06, then 0x02 00 00 20 AB -> mem[0x20]=0xAB and a following 0x05 returns 0x00.
REQ-037 Bench SHALL send 0x9F and read 4 bytes -> 0xEF, 0x40, 0x18, 0x00.
REQ-038 Bench SHALL raise csn after 3 bits of an address byte in 0x03 -> IDLE on that edge, oen=4'hF; the next 0x03 transaction returns correct data.
REQ-039 Bench SHALL send opcode 0xAA, then hold clk_en low for 5 cycles mid-read -> IGNORE with no driving; on the stalled read the outputs stay frozen and the data resumes intact.
